// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC snapshot initiator and the RTC register block:
// sequencer state encoding, register map defaults and the capture command value.
package rtc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CAPT = 3'd1,
    ST_GAP1 = 3'd2,
    ST_RDT  = 3'd3,
    ST_GAP2 = 3'd4,
    ST_RDD  = 3'd5,
    ST_DONE = 3'd6
  } rtc_snap_st_e;

  localparam logic [4:0]  RTC_CMD_ADDR    = 5'h10;
  localparam logic [4:0]  RTC_TIME_ADDR   = 5'h00;
  localparam logic [4:0]  RTC_DATE_ADDR   = 5'h04;
  localparam logic [31:0] RTC_CMD_CAPTURE = 32'h0000_0002;
  localparam logic [3:0]  RTC_BE_ALL      = 4'hF;

  // States that own the register bus (reg_cs high).
  function automatic logic rtc_is_bus_st(input rtc_snap_st_e st);
    return (st == ST_CAPT) || (st == ST_RDT) || (st == ST_RDD);
  endfunction

endpackage

// File: rtl/rtc_poll_timer.sv
// Reload down-counter that pulses expire once every `period` cycles while enabled
// (period 0 behaves as 1). Reloads on enable rise and on every expiry.
module rtc_poll_timer (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] period,
  output logic        expire
);

  logic [15:0] cnt_q, cnt_d;
  logic        en_q;
  logic [15:0] reload;

  always_comb begin
    reload = (period == 16'd0) ? 16'd1 : period;
    expire = 1'b0;
    cnt_d  = reload;
    if (en && en_q) begin
      if (cnt_q <= 16'd1) begin
        expire = 1'b1;
      end else begin
        cnt_d = cnt_q - 16'd1;
      end
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 16'd0;
      en_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      en_q  <= en;
    end
  end

endmodule

// File: rtl/rtc_snap_master.sv
// Register-bus initiator: capture command, time read, date read, then an atomic
// 64-bit snapshot update. Each transaction is guarded by an ack timeout.
module rtc_snap_master import rtc_pkg::*; #(
  parameter logic [4:0]  CMD_ADDR  = RTC_CMD_ADDR,
  parameter logic [31:0] CMD_WDATA = RTC_CMD_CAPTURE,
  parameter logic [4:0]  TIME_ADDR = RTC_TIME_ADDR,
  parameter logic [4:0]  DATE_ADDR = RTC_DATE_ADDR,
  parameter int unsigned TIMEOUT   = 256
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic        snap_req,
  input  logic        cfg_poll_en,
  input  logic [15:0] cfg_poll_period,
  output logic        busy,
  output logic        snap_valid,
  output logic        snap_err,
  output logic [31:0] snap_time,
  output logic [31:0] snap_date,
  output logic        reg_cs,
  output logic [4:0]  reg_addr,
  output logic [31:0] reg_wdata,
  output logic [3:0]  reg_be,
  output logic        reg_wr,
  input  logic [31:0] reg_rdata,
  input  logic        reg_ack
);

  localparam int TW = $clog2(TIMEOUT + 1);

  rtc_snap_st_e state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [31:0]   hold_q, hold_d;
  logic [31:0]   snap_time_q, snap_time_d;
  logic [31:0]   snap_date_q, snap_date_d;
  logic          err_q, err_d;
  logic          poll_expire;
  logic          start;
  logic          tmo_hit;

  rtc_poll_timer u_poll_timer (
    .sys_clk (sys_clk),
    .rst     (rst),
    .en      (cfg_poll_en),
    .period  (cfg_poll_period),
    .expire  (poll_expire)
  );

  assign start   = snap_req || (cfg_poll_en && poll_expire);
  assign tmo_hit = rtc_is_bus_st(state_q) && !reg_ack && (tmo_q == TW'(TIMEOUT - 1));

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      tmo_q       <= '0;
      hold_q      <= '0;
      snap_time_q <= '0;
      snap_date_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      hold_q      <= hold_d;
      snap_time_q <= snap_time_d;
      snap_date_q <= snap_date_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_CAPT;
      ST_CAPT: if (reg_ack) state_d = ST_GAP1; else if (tmo_hit) state_d = ST_IDLE;
      ST_GAP1: state_d = ST_RDT;
      ST_RDT:  if (reg_ack) state_d = ST_GAP2; else if (tmo_hit) state_d = ST_IDLE;
      ST_GAP2: state_d = ST_RDD;
      ST_RDD:  if (reg_ack) state_d = ST_DONE; else if (tmo_hit) state_d = ST_IDLE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Both snapshot words load on the same edge (date ack), so they first become
  // visible together in the DONE cycle alongside snap_valid.
  always_comb begin
    tmo_d       = '0;
    hold_d      = hold_q;
    snap_time_d = snap_time_q;
    snap_date_d = snap_date_q;
    err_d       = tmo_hit;
    if (rtc_is_bus_st(state_q) && (state_d == state_q)) begin
      tmo_d = tmo_q + TW'(1);
    end
    if ((state_q == ST_RDT) && reg_ack) begin
      hold_d = reg_rdata;
    end
    if ((state_q == ST_RDD) && reg_ack) begin
      snap_time_d = hold_q;
      snap_date_d = reg_rdata;
    end
  end

  always_comb begin
    reg_cs    = 1'b0;
    reg_addr  = '0;
    reg_wdata = '0;
    reg_wr    = 1'b0;
    case (state_q)
      ST_CAPT: begin
        reg_cs    = 1'b1;
        reg_addr  = CMD_ADDR;
        reg_wdata = CMD_WDATA;
        reg_wr    = 1'b1;
      end
      ST_RDT: begin
        reg_cs   = 1'b1;
        reg_addr = TIME_ADDR;
      end
      ST_RDD: begin
        reg_cs   = 1'b1;
        reg_addr = DATE_ADDR;
      end
      default: begin
      end
    endcase
  end

  assign reg_be     = RTC_BE_ALL;
  assign busy       = (state_q != ST_IDLE);
  assign snap_valid = (state_q == ST_DONE);
  assign snap_err   = err_q;
  assign snap_time  = snap_time_q;
  assign snap_date  = snap_date_q;

endmodule

// File: doc/rtc_snap_master.md
# rtc_snap_master

Register-bus initiator that drives the RTC register interface (`reg_cs`/`reg_addr`/`reg_wdata`/`reg_be`/`reg_wr` out, `reg_rdata`/`reg_ack` in) from the system-clock side. On a software request or periodic poll it runs a fixed sequence:

- write the capture command;
- read the time word;
- read the date word.

It then presents an atomic 64-bit time+date snapshot to local consumers (sensor timestamping, log unit) without CPU involvement. It sits in the sys_clk domain, on the initiator side of the RTC's asynchronous register bridge.

## Interface
Parameters:
- `CMD_ADDR`, 5'h10: RTC control register address (capture command target)
- `CMD_WDATA`, 32'h0000_0002: data written to trigger capture
- `TIME_ADDR`, 5'h00: packed time register address
- `DATE_ADDR`, 5'h04: packed date register address
- `TIMEOUT`, 256: max cycles waiting for `reg_ack` per transaction (≥2)

Ports:
- `sys_clk` in 1: the only clock
- `rst` in 1: reset, asynchronous, active-high
- `snap_req` in 1: single-cycle start request
- `cfg_poll_en` in 1: enable periodic snapshots
- `cfg_poll_period` in 16: poll interval in sys_clk cycles (0 treated as 1)
- `busy` out 1: sequence in progress
- `snap_valid` out 1: one-cycle pulse, snapshot updated
- `snap_err` out 1: one-cycle pulse, transaction timed out
- `snap_time` out 32: last captured time word
- `snap_date` out 32: last captured date word
- `reg_cs` out 1: bus request, held until ack
- `reg_addr` out 5: bus address
- `reg_wdata` out 32: write data
- `reg_be` out 4: byte enables (always 4'hF)
- `reg_wr` out 1: 1 = write, 0 = read
- `reg_rdata` in 32: read data, valid with `reg_ack`
- `reg_ack` in 1: transaction complete

## Operation
- FSM states:
  - IDLE
  - CAPT: write `CMD_WDATA` to `CMD_ADDR`
  - GAP1
  - RDT: read `TIME_ADDR`
  - GAP2
  - RDD: read `DATE_ADDR`
  - DONE
- IDLE exits to CAPT on a start event. A start event is `snap_req`, or poll timer expiry while `cfg_poll_en` is set.
- Each bus state drives `reg_cs=1`. Address, data and `reg_wr` are stable for the whole state. On `reg_ack=1` the FSM advances to the next state.
- The GAP states hold `reg_cs=0` for exactly one cycle, so every transaction is separated by at least one deasserted cycle.
- RDT latches `reg_rdata` into a holding register on ack. RDD latches the date and moves to DONE.
- DONE copies the holding register and the date to `snap_time`/`snap_date` in the same cycle and pulses `snap_valid`. The two outputs therefore never show a mixed snapshot.
- Timeout: a per-transaction counter clears on bus-state entry and increments while `reg_cs` is high without ack.
  - At `TIMEOUT` cycles: drop `reg_cs`, pulse `snap_err`, return to IDLE.
  - `snap_time`/`snap_date` are unchanged.
- Start events while `busy` are dropped, not queued. `snap_req` and poll expiry in the same cycle start a single sequence.
- Poll timer:
  - Reloads `cfg_poll_period` when `cfg_poll_en` rises and on each expiry.
  - Counts down every cycle, including while busy. An expiry while busy is lost.
  - Held at reload value while disabled.
- `reg_ack` seen outside a bus state is ignored.

## Timing
- Reset values: all outputs 0, `reg_be`=4'hF, FSM in IDLE, poll counter = 0 (reloaded on enable).
- `snap_req` at cycle 0 gives `reg_cs`=1 at cycle 1. `busy` is high from cycle 1 through the DONE cycle inclusive.
- Minimum sequence (ack in the first cs cycle of each transaction):
  - CAPT @1
  - GAP1 @2
  - RDT @3
  - GAP2 @4
  - RDD @5
  - `snap_valid` @6
  - New request accepted @7
- Each extra ack-wait cycle adds one cycle of latency.
- `reg_cs` falls the cycle after ack is sampled.
- `snap_err` is asserted in the cycle after the `TIMEOUT`-th wait cycle, coincident with `reg_cs` falling.
- Asynchronous `rst` mid-transaction: `reg_cs` drops immediately; no snapshot update and no error pulse.

## Structure
- `rtc_pkg`: state enum `rtc_snap_st_e`, default address/command localparams shared with the RTC register block.
- Sub-module `rtc_poll_timer`: 16-bit reload down-counter with enable and expiry pulse.
- Top: FSM, timeout counter, holding/snapshot registers.

## Test plan
- Zero-wait responder, `snap_req` @0 → writes 32'h2 to 5'h10, reads 5'h00 then 5'h04, `snap_valid` @6, `snap_time`/`snap_date` equal the returned data (e.g. 32'h0012_3045 / 32'h2022_1118).
- Responder with 3-cycle ack delay per transaction → `snap_valid` @12; `reg_cs` and address stable throughout each wait; `reg_cs` low for exactly one cycle between transactions.
- Responder never acks in RDT, `TIMEOUT`=16 → `snap_err` pulses once; `reg_cs` drops; previous snapshot retained; next `snap_req` works.
- `cfg_poll_en`=1, period=100, zero-wait responder → `snap_valid` every 100 cycles; `snap_req` issued mid-sequence is ignored (no extra bus traffic).
- `rst` asserted while waiting in RDD → `reg_cs`=0 asynchronously; no `snap_valid`/`snap_err`; outputs at reset values.
